// File: rtl/arbiter_pkg.sv
// Shared types and constants for the round-robin arbiter.
package arbiter_pkg;

  // Two-state arbiter FSM; the spare encodings recover to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1
  } state_t;

  // Width of the hold counter; covers HOLD_MAX up to 255.
  localparam int unsigned HOLD_CNT_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set req bit at or after start, wrapping.
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [W:0]   sum;
  logic [W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      sum = {1'b0, start} + (W+1)'(i);
      if (sum >= (W+1)'(N)) begin
        sum = sum - (W+1)'(N);
      end
      cand = sum[W-1:0];
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/arbiter_rr.sv
// Round-robin arbiter with registered one-hot grant.
// Optional macro ARBITER_RR_HOLD_LIMIT_EN: preempt a grant held HOLD_MAX
// cycles when another requester is waiting.
module arbiter_rr
  import arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       gnt_valid,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  state_t                state;
  logic [ID_W-1:0]       last_id;
  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic [ID_W-1:0]       start;
  logic                  found;
  logic [ID_W-1:0]       win;
  logic                  take;
  logic                  drop;

  // Search begins just after the most recent winner.
  always_comb begin
    start = (last_id == ID_W'(NUM_REQ - 1)) ? '0 : last_id + 1'b1;
  end

  rr_pick #(
    .N (NUM_REQ),
    .W (ID_W)
  ) u_pick (
    .req   (req),
    .start (start),
    .found (found),
    .idx   (win)
  );

  // Decide whether this edge loads a new winner or releases the bus.
  always_comb begin
    take = 1'b0;
    drop = 1'b0;
    case (state)
      IDLE: take = found;
      GRANT: begin
        if (!req[gnt_id]) begin
          take = found;
          drop = ~found;
        end
`ifdef ARBITER_RR_HOLD_LIMIT_EN
        else if (|(req & ~gnt) && hold_cnt == HOLD_CNT_W'(HOLD_MAX - 1)) begin
          take = 1'b1;
        end
`endif
      end
      default: drop = 1'b1;
    endcase
  end

  // State, grant outputs, priority pointer and hold counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      last_id   <= ID_W'(NUM_REQ - 1);
      hold_cnt  <= '0;
    end else if (take) begin
      state     <= GRANT;
      gnt       <= NUM_REQ'(1) << win;
      gnt_valid <= 1'b1;
      gnt_id    <= win;
      last_id   <= win;
      hold_cnt  <= '0;
    end else if (drop) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      hold_cnt  <= '0;
    end else if (state == GRANT && hold_cnt != HOLD_CNT_W'(HOLD_MAX)) begin
      hold_cnt  <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_arbiter_rr.sv
// Self-checking bench for arbiter_rr with a behavioural round-robin model.
module tb_arbiter_rr;

  localparam int N    = 4;
  localparam int HOLD = 4;
`ifdef ARBITER_RR_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req   = '0;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_id;

  int total = 0;
  int bad   = 0;

  // Model state: current owner (-1 = none), last winner, cycles held.
  int m_cur  = -1;
  int m_last = N - 1;
  int m_hold = 0;

  arbiter_rr #(.NUM_REQ(N), .HOLD_MAX(HOLD)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_gnt(input int cur);
    logic [N-1:0] v;
    v = '0;
    if (cur >= 0) v[cur] = 1'b1;
    return v;
  endfunction

  // Reference model: advance on every edge from the spec's rules.
  always @(posedge clock or posedge reset) begin : model
    int c, l, h, w;
    logic [N-1:0] others;
    if (reset) begin
      m_cur  <= -1;
      m_last <= N - 1;
      m_hold <= 0;
    end else begin
      c = m_cur; l = m_last; h = m_hold;
      w = pick(req, l);
      others = req & ~exp_gnt(c);
      if (c < 0 || !req[c]) begin
        if (w >= 0) begin c = w; l = w; h = 0; end
        else begin c = -1; h = 0; end
      end else if (HOLD_EN && h == HOLD - 1 && others != '0) begin
        c = w; l = w; h = 0;
      end else if (h < HOLD) begin
        h++;
      end
      m_cur  <= c;
      m_last <= l;
      m_hold <= h;
    end
  end

  // Every-cycle comparison against the model plus structural invariants.
  always @(negedge clock) begin
    chk("gnt", 32'(gnt), 32'(exp_gnt(m_cur)));
    chk("gnt_valid", 32'(gnt_valid), 32'(m_cur >= 0));
    chk("gnt_id", 32'(gnt_id), (m_cur < 0) ? 32'd0 : 32'(m_cur));
    chk("onehot0", 32'($onehot0(gnt)), 32'd1);
    chk("valid_or", 32'(gnt_valid), 32'(|gnt));
  end

  task automatic do_reset();
    req   = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin : stim
    // Reset state
    @(negedge clock);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_id", 32'(gnt_id), 32'd0);
    reset = 1'b0;

    // Single requester then release
    req = 4'b0001;
    @(negedge clock);
    chk("single_gnt", 32'(gnt), 32'h1);
    chk("single_id", 32'(gnt_id), 32'd0);
    req = 4'b0000;
    @(negedge clock);
    chk("release_gnt", 32'(gnt), 32'h0);

    // Rotation: owner drops after one granted cycle, others keep requesting
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] e;
      @(negedge clock);
      e = '0;
      e[k % N] = 1'b1;
      chk("rot_gnt", 32'(gnt), 32'(e));
      chk("rot_model", 32'(exp_gnt(m_cur)), 32'(e));
      req = 4'b1111 & ~e;
    end

`ifdef ARBITER_RR_HOLD_LIMIT_EN
    // Preemption alternates two held requesters every HOLD cycles
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      chk("preempt_gnt", 32'(gnt), ((i / 4) % 2 == 1) ? 32'h2 : 32'h1);
      chk("preempt_model", 32'(exp_gnt(m_cur)), ((i / 4) % 2 == 1) ? 32'h2 : 32'h1);
    end
`else
    // No preemption: first winner keeps the grant
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("hold_gnt", 32'(gnt), 32'h1);
    end
`endif

    // Asynchronous reset mid-grant
    do_reset();
    req = 4'b0100;
    @(negedge clock);
    chk("pre_rst_gnt", 32'(gnt), 32'h4);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'h0);
    chk("async_rst_valid", 32'(gnt_valid), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    req = 4'b1111;
    @(negedge clock);
    chk("post_rst_gnt", 32'(gnt), 32'h1);

    // Randomized sticky requests with occasional async resets
    do_reset();
    for (int i = 0; i < 800; i++) begin
      @(negedge clock);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(3) == 0) req[b] = ~req[b];
      end
      if ($urandom_range(40) == 0) req = '0;
      if ($urandom_range(100) == 0) begin
        @(posedge clock);
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
    end

    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
